dcache_wb: RTL and testbench
============================

# dcache_wb

Parametrised, direct-mapped, write-back, write-allocate data cache for the core's load/store port. It succeeds the fixed 128-bit-line write-through arrangement. Line count and words-per-line are parameters, lines carry dirty bits, and memory traffic uses a registered request/ready handshake. A flush walks the whole array and writes back dirty lines before invalidating. The block sits between the core (address/wdata/read/write/stall) and the backing memory model.

## Interface
- WIDTH, 32, data and address width in bits.
- LINES, 16, number of cache lines; power of two, ≥2.
- WORDS, 4, WIDTH-bit words per line; power of two, ≥1.
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset, synchronous and active-low.
- address  in  WIDTH  byte address; bits [1:0] ignored.
- wdata  in  WIDTH  store data.
- read  in  1  load request.
- write  in  1  store request; read and write never asserted together.
- flush  in  1  single-cycle flush request.
- rdata  out  WIDTH  load data.
- stall  out  1  core must hold address/wdata/read/write stable while high.
- mem_read  out  1  line refill request.
- mem_write  out  1  line write-back request.
- mem_addr  out  WIDTH  line-aligned memory address.
- mem_wdata  out  WIDTH*WORDS  write-back line, word 0 in the LSBs.
- mem_rdata  in  WIDTH*WORDS  refill line, word 0 in the LSBs.
- mem_ready  in  1  completes the current mem_read/mem_write in the same cycle.

## Operation
- Address fields, LSB up: 2 byte bits, log2(WORDS) word-select bits, log2(LINES) index bits, remaining bits tag.
- Per-line storage: valid, dirty, tag, WORDS data words.
- Hit: request, valid[index], and tag match.
- States: IDLE, WRITEBACK, REFILL, FLUSH_SCAN, FLUSH_WB.
- IDLE, read hit: rdata = addressed word combinationally; stall low.
- IDLE, write hit: word written and dirty set at the clock edge; stall low.
- IDLE, miss: stall high combinationally.
  - Victim valid and dirty: go to WRITEBACK.
  - Otherwise: go to REFILL.
- WRITEBACK: mem_write=1, mem_addr = {victim tag, index, 0}, mem_wdata = victim line. On mem_ready, go to REFILL.
- REFILL: mem_read=1, mem_addr = {request tag, index, 0}. On mem_ready, install mem_rdata with valid=1, dirty=0, and the new tag, then return to IDLE.
  - Back in IDLE the held request hits: a read returns data, a write merges and sets dirty.
- flush sampled in IDLE: go to FLUSH_SCAN with line counter = 0.
  - FLUSH_SCAN: if line[counter] is valid and dirty, go to FLUSH_WB. Otherwise clear valid, then increment the counter or return to IDLE after LINES-1.
  - FLUSH_WB: same handshake as WRITEBACK. On mem_ready, clear valid and dirty, then advance as in FLUSH_SCAN.
- stall is high in every non-IDLE state.
- rdata = 0 whenever no read hit is in IDLE.
- mem_read and mem_write are never both high.
- mem_addr and mem_wdata are 0 when neither is asserted.

## Timing
- Reset (rst=0 at an edge) sets: state IDLE, all valid and dirty bits 0, mem_read=0, mem_write=0, stall=0, rdata=0, flush counter 0. Data and tag contents are don't-care.
- Reset mid-transaction abandons the transaction at that edge. Memory sees mem_read/mem_write drop the following cycle.
- Hit latency: 0 cycles (combinational read data; write committed at the edge).
- Clean miss: stall high for 1 + R cycles, where R is cycles until mem_ready. The data is returned in the first IDLE cycle after that.
- Dirty miss adds W write-back cycles.
- mem_read, mem_write, and mem_addr are registered state outputs, held stable until mem_ready.
- mem_ready is ignored when no request is asserted.
- flush together with read/write in IDLE: flush wins. The access is stalled and serviced after the flush completes.
- flush arriving outside IDLE is ignored.
- Clean flush takes exactly LINES cycles of stall.

## Structure
- Shared package dcache_pkg holds:
  - the state enum;
  - the field-width localparams (OFF_W, IDX_W, TAG_W) derived from WIDTH/LINES/WORDS;
  - the line-address packing function.
- Sub-module dcache_line_store holds the valid/dirty/tag/data arrays. It has one combinational read port, a word-write port, a line-install port, and a per-line invalidate.
- The FSM and the memory interface live in dcache_wb.

## Test plan
Use defaults LINES=16, WORDS=4: index = address[7:4], word = address[3:2].
1. Reset, then read 0x0000_0040 with memory word = 0xA5A5_0001. Required: mem_read with mem_addr 0x40, stall released, rdata 0xA5A5_0001. The repeat read hits with stall low.
2. Write 0xDEAD_BEEF to 0x44 after refill. Required: no memory traffic, dirty set. A read of 0x44 returns 0xDEAD_BEEF.
3. Read 0x1040, same index as the dirty 0x40 line. Required: mem_write at 0x40 with word 1 = 0xDEAD_BEEF, then mem_read at 0x1040.
4. Flush with 2 dirty lines of 16 and mem_ready after 3 cycles. Required: exactly 2 write-backs, stall for 16+2·3 cycles, then all lines miss.
5. Assert rst=0 during REFILL. Required: mem_read drops the next cycle, stall=0, and the next read of the same address misses.
6. flush and read asserted in the same cycle. Required: flush completes first, then the read is serviced with correct data.

Source files
------------

// File: rtl/dcache_pkg.sv
// dcache_pkg: shared definitions for the write-back data cache.
//   - state_t and the S_* state encodings
//   - helper functions that size the address fields from WIDTH/LINES/WORDS
//   - OFF_W/IDX_W/TAG_W for the default 32-bit, 16-line, 4-word configuration
//   - line_addr(): builds a line-aligned byte address from tag and index
package dcache_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE       = 3'd0;
  localparam state_t S_WRITEBACK  = 3'd1;
  localparam state_t S_REFILL     = 3'd2;
  localparam state_t S_FLUSH_SCAN = 3'd3;
  localparam state_t S_FLUSH_WB   = 3'd4;

  localparam int unsigned DEF_WIDTH = 32;
  localparam int unsigned DEF_LINES = 16;
  localparam int unsigned DEF_WORDS = 4;

  // Byte-offset bits: 2 byte bits plus the word-select bits.
  function automatic int unsigned off_w_f(input int unsigned words);
    return 2 + $clog2(words);
  endfunction

  function automatic int unsigned idx_w_f(input int unsigned lines);
    return $clog2(lines);
  endfunction

  // Word-select field is kept at least 1 bit wide so single-word lines still elaborate.
  function automatic int unsigned sel_w_f(input int unsigned words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

  localparam int unsigned OFF_W = off_w_f(DEF_WORDS);
  localparam int unsigned IDX_W = idx_w_f(DEF_LINES);
  localparam int unsigned TAG_W = DEF_WIDTH - OFF_W - IDX_W;

  // {tag, index, zero offset}; callers cast the result down to their address width.
  function automatic logic [63:0] line_addr(input logic [63:0] tag, input logic [63:0] idx,
                                            input int unsigned idx_w, input int unsigned off_w);
    return (tag << (idx_w + off_w)) | (idx << off_w);
  endfunction

endpackage

// File: rtl/dcache_line_store.sv
// dcache_line_store: valid/dirty/tag/data arrays of the direct-mapped cache.
//   clk, rst        : clock, synchronous active-low reset (clears valid and dirty only)
//   rd_*            : combinational read port (valid, dirty, tag, whole line) at rd_idx_i
//   wr_*            : single-word store into a line; marks the line dirty
//   inst_*          : whole-line install; sets valid, clears dirty, loads tag
//   inv_*           : per-line invalidate; clears valid and dirty
module dcache_line_store
  import dcache_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned LINES = DEF_LINES,
  parameter int unsigned WORDS = DEF_WORDS,
  localparam int unsigned IDX_BITS  = idx_w_f(LINES),
  localparam int unsigned TAG_BITS  = WIDTH - off_w_f(WORDS) - idx_w_f(LINES),
  localparam int unsigned SEL_BITS  = sel_w_f(WORDS),
  localparam int unsigned LINE_BITS = WIDTH * WORDS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [IDX_BITS-1:0]  rd_idx_i,
  output logic                 rd_valid_o,
  output logic                 rd_dirty_o,
  output logic [TAG_BITS-1:0]  rd_tag_o,
  output logic [LINE_BITS-1:0] rd_line_o,
  input  logic                 wr_en_i,
  input  logic [IDX_BITS-1:0]  wr_idx_i,
  input  logic [SEL_BITS-1:0]  wr_sel_i,
  input  logic [WIDTH-1:0]     wr_data_i,
  input  logic                 inst_en_i,
  input  logic [IDX_BITS-1:0]  inst_idx_i,
  input  logic [TAG_BITS-1:0]  inst_tag_i,
  input  logic [LINE_BITS-1:0] inst_line_i,
  input  logic                 inv_en_i,
  input  logic [IDX_BITS-1:0]  inv_idx_i
);

  logic [LINES-1:0]     valid_q;
  logic [LINES-1:0]     dirty_q;
  logic [TAG_BITS-1:0]  tag_q  [LINES];
  logic [LINE_BITS-1:0] data_q [LINES];

  // Status bits; the controller never raises more than one update in a cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (inst_en_i) begin
      valid_q[inst_idx_i] <= 1'b1;
      dirty_q[inst_idx_i] <= 1'b0;
    end else if (wr_en_i) begin
      dirty_q[wr_idx_i] <= 1'b1;
    end else if (inv_en_i) begin
      valid_q[inv_idx_i] <= 1'b0;
      dirty_q[inv_idx_i] <= 1'b0;
    end
  end

  // Tag and data contents are don't-care after reset, so they carry no reset.
  always_ff @(posedge clk) begin
    if (inst_en_i) begin
      tag_q[inst_idx_i]  <= inst_tag_i;
      data_q[inst_idx_i] <= inst_line_i;
    end else if (wr_en_i) begin
      data_q[wr_idx_i][32'(wr_sel_i) * WIDTH +: WIDTH] <= wr_data_i;
    end
  end

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_dirty_o = dirty_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_line_o  = data_q[rd_idx_i];

endmodule

// File: rtl/dcache_wb.sv
// dcache_wb: direct-mapped, write-back, write-allocate data cache with flush.
//   clk, rst                  : clock, synchronous active-low reset
//   address/wdata/read/write  : core load/store request (held while stall is high)
//   flush                     : single-cycle request to write back and invalidate all lines
//   rdata, stall              : combinational load data and core hold
//   mem_read/mem_write        : registered line refill / write-back requests
//   mem_addr/mem_wdata        : registered line address and write-back line (0 when idle)
//   mem_rdata, mem_ready      : refill line and same-cycle completion from memory
module dcache_wb
  import dcache_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned LINES = DEF_LINES,
  parameter int unsigned WORDS = DEF_WORDS
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH-1:0]       address,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   read,
  input  logic                   write,
  input  logic                   flush,
  output logic [WIDTH-1:0]       rdata,
  output logic                   stall,
  output logic                   mem_read,
  output logic                   mem_write,
  output logic [WIDTH-1:0]       mem_addr,
  output logic [WIDTH*WORDS-1:0] mem_wdata,
  input  logic [WIDTH*WORDS-1:0] mem_rdata,
  input  logic                   mem_ready
);

  localparam int unsigned OFF_BITS  = off_w_f(WORDS);
  localparam int unsigned IDX_BITS  = idx_w_f(LINES);
  localparam int unsigned TAG_BITS  = WIDTH - OFF_BITS - IDX_BITS;
  localparam int unsigned SEL_BITS  = sel_w_f(WORDS);
  localparam int unsigned LINE_BITS = WIDTH * WORDS;

  state_t               state_q, state_d;
  logic [IDX_BITS-1:0]  cnt_q, cnt_d;
  logic                 mem_read_q, mem_read_d;
  logic                 mem_write_q, mem_write_d;
  logic [WIDTH-1:0]     mem_addr_q, mem_addr_d;
  logic [LINE_BITS-1:0] mem_wdata_q, mem_wdata_d;

  logic [SEL_BITS-1:0]  req_sel;
  logic [IDX_BITS-1:0]  req_idx;
  logic [TAG_BITS-1:0]  req_tag;
  logic                 req, hit, flushing;
  logic [IDX_BITS-1:0]  rd_idx;
  logic                 rd_valid, rd_dirty;
  logic [TAG_BITS-1:0]  rd_tag;
  logic [LINE_BITS-1:0] rd_line;
  logic                 wr_en, inst_en, inv_en;

  function automatic logic [WIDTH-1:0] pack_addr(input logic [TAG_BITS-1:0] t,
                                                 input logic [IDX_BITS-1:0] i);
    return WIDTH'(line_addr(64'(t), 64'(i), IDX_BITS, OFF_BITS));
  endfunction

  // Address split: byte bits, word select, index, tag.
  assign req_sel = SEL_BITS'((address >> 2) & WIDTH'(WORDS - 1));
  assign req_idx = IDX_BITS'(address >> OFF_BITS);
  assign req_tag = TAG_BITS'(address >> (OFF_BITS + IDX_BITS));

  assign req      = read | write;
  assign flushing = (state_q == S_FLUSH_SCAN) || (state_q == S_FLUSH_WB);
  assign rd_idx   = flushing ? cnt_q : req_idx;
  assign hit      = rd_valid && (rd_tag == req_tag);

  dcache_line_store #(
    .WIDTH (WIDTH),
    .LINES (LINES),
    .WORDS (WORDS)
  ) u_store (
    .clk         (clk),
    .rst         (rst),
    .rd_idx_i    (rd_idx),
    .rd_valid_o  (rd_valid),
    .rd_dirty_o  (rd_dirty),
    .rd_tag_o    (rd_tag),
    .rd_line_o   (rd_line),
    .wr_en_i     (wr_en),
    .wr_idx_i    (req_idx),
    .wr_sel_i    (req_sel),
    .wr_data_i   (wdata),
    .inst_en_i   (inst_en),
    .inst_idx_i  (req_idx),
    .inst_tag_i  (req_tag),
    .inst_line_i (mem_rdata),
    .inv_en_i    (inv_en),
    .inv_idx_i   (cnt_q)
  );

  // A flush sampled together with an access wins, so the access is held off.
  assign stall = (state_q != S_IDLE) || (req && (!hit || flush));
  assign rdata = (state_q == S_IDLE && read && hit && !flush)
               ? rd_line[32'(req_sel) * WIDTH +: WIDTH] : '0;

  // Next-state, memory-request and array-update decode.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    wr_en       = 1'b0;
    inst_en     = 1'b0;
    inv_en      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (flush) begin
          state_d = S_FLUSH_SCAN;
          cnt_d   = '0;
        end else if (req && !hit) begin
          if (rd_valid && rd_dirty) begin
            state_d     = S_WRITEBACK;
            mem_write_d = 1'b1;
            mem_addr_d  = pack_addr(rd_tag, req_idx);
            mem_wdata_d = rd_line;
          end else begin
            state_d    = S_REFILL;
            mem_read_d = 1'b1;
            mem_addr_d = pack_addr(req_tag, req_idx);
          end
        end else if (write && hit) begin
          wr_en = 1'b1;
        end
      end
      S_WRITEBACK: begin
        if (mem_ready) begin
          state_d     = S_REFILL;
          mem_write_d = 1'b0;
          mem_read_d  = 1'b1;
          mem_addr_d  = pack_addr(req_tag, req_idx);
          mem_wdata_d = '0;
        end
      end
      S_REFILL: begin
        if (mem_ready) begin
          state_d    = S_IDLE;
          inst_en    = 1'b1;
          mem_read_d = 1'b0;
          mem_addr_d = '0;
        end
      end
      S_FLUSH_SCAN: begin
        if (rd_valid && rd_dirty) begin
          state_d     = S_FLUSH_WB;
          mem_write_d = 1'b1;
          mem_addr_d  = pack_addr(rd_tag, cnt_q);
          mem_wdata_d = rd_line;
        end else begin
          inv_en = 1'b1;
          if (cnt_q == IDX_BITS'(LINES - 1)) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + IDX_BITS'(1);
          end
        end
      end
      S_FLUSH_WB: begin
        if (mem_ready) begin
          inv_en      = 1'b1;
          mem_write_d = 1'b0;
          mem_addr_d  = '0;
          mem_wdata_d = '0;
          if (cnt_q == IDX_BITS'(LINES - 1)) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end else begin
            state_d = S_FLUSH_SCAN;
            cnt_d   = cnt_q + IDX_BITS'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and registered memory-interface outputs; reset abandons any transaction.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_dcache_wb.sv
// tb_dcache_wb: self-checking bench for dcache_wb (default 32-bit, 16 lines, 4 words).
// A behavioural line memory answers requests after a programmable latency; load results
// are predicted from an architectural word model and queued until the cache returns them.
module tb_dcache_wb;

  logic         clk = 1'b0;
  logic         rst, read, write, flush, mem_ready;
  logic [31:0]  address, wdata, rdata, mem_addr;
  logic         stall, mem_read, mem_write;
  logic [127:0] mem_wdata, mem_rdata;

  int errors = 0;
  int checks = 0;
  int lat    = 1;
  int busy;

  logic [31:0]  exp_q[$];
  logic [31:0]  wb_addr_q[$];
  logic [127:0] wb_data_q[$];
  logic [127:0] mem_lines [logic [31:0]];
  logic [31:0]  core_ref  [logic [31:0]];

  bit          rd_seen, wr_seen;
  logic [31:0] rd_addr, wr_addr;
  int          n_wb;

  always #5 clk = ~clk;

  dcache_wb dut (
    .clk       (clk),
    .rst       (rst),
    .address   (address),
    .wdata     (wdata),
    .read      (read),
    .write     (write),
    .flush     (flush),
    .rdata     (rdata),
    .stall     (stall),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready)
  );

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Background memory contents for a word address.
  function automatic logic [31:0] pat(input logic [31:0] a);
    return 32'hA5A5_0000 ^ ((a >> 6) & 32'h3FFF) ^ (((a >> 2) & 32'h3) << 14);
  endfunction

  function automatic logic [127:0] mem_get(input logic [31:0] la);
    logic [127:0] l;
    if (mem_lines.exists(la)) return mem_lines[la];
    for (int w = 0; w < 4; w++) l[w*32 +: 32] = pat(la + 32'(w * 4));
    return l;
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    logic [31:0] wa;
    wa = a & ~32'h3;
    if (core_ref.exists(wa)) return core_ref[wa];
    return pat(wa);
  endfunction

  // Memory responder: mem_ready in the lat-th cycle of each request.
  initial begin
    busy      = 0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      mem_ready = 1'b0;
      if (rst && (mem_read || mem_write)) begin
        if (busy >= lat - 1) begin
          mem_ready = 1'b1;
          busy      = 0;
          if (mem_write) begin
            wb_addr_q.push_back(mem_addr);
            wb_data_q.push_back(mem_wdata);
            mem_lines[mem_addr] = mem_wdata;
          end else begin
            mem_rdata = mem_get(mem_addr);
          end
        end else begin
          busy++;
        end
      end else begin
        busy = 0;
      end
    end
  end

  // One core access; counts stall cycles and records the first memory requests seen.
  task automatic do_access(input logic [31:0] a, input bit wr, input logic [31:0] d,
                           input bit fl, input int exp_stall, input string tag);
    int n;
    logic [31:0] e;
    n       = 0;
    rd_seen = 1'b0;
    wr_seen = 1'b0;
    address = a;
    wdata   = d;
    read    = !wr;
    write   = wr;
    flush   = fl;
    if (wr) core_ref[a & ~32'h3] = d;
    else    exp_q.push_back(ref_word(a));
    #1;
    if (fl) check({tag, "_flush_rdata"}, 128'(rdata), 128'(0));
    while (stall && n < 400) begin
      n++;
      check({tag, "_excl"}, 128'(mem_read & mem_write), 128'(0));
      if (mem_read && !rd_seen) begin rd_seen = 1'b1; rd_addr = mem_addr; end
      if (mem_write && !wr_seen) begin wr_seen = 1'b1; wr_addr = mem_addr; end
      @(posedge clk); #1;
      flush = 1'b0;
      #1;
    end
    check({tag, "_stall_low"}, 128'(stall), 128'(0));
    check({tag, "_stall_cycles"}, 128'(n), 128'(exp_stall));
    if (!wr) begin
      e = exp_q.pop_front();
      check({tag, "_rdata"}, 128'(rdata), 128'(e));
    end
    @(posedge clk); #1;
    read  = 1'b0;
    write = 1'b0;
  endtask

  task automatic do_flush(input int exp_stall);
    int n;
    n     = 0;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    #1;
    while (stall && n < 400) begin
      n++;
      @(posedge clk); #2;
    end
    check("flush_stall_low", 128'(stall), 128'(0));
    check("flush_stall_cycles", 128'(n), 128'(exp_stall));
    @(posedge clk); #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    rst = 1'b0; read = 1'b0; write = 1'b0; flush = 1'b0;
    address = '0; wdata = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("rst_stall", 128'(stall), 128'(0));
    check("rst_mem_read", 128'(mem_read), 128'(0));
    check("rst_mem_write", 128'(mem_write), 128'(0));
    check("rst_mem_addr", 128'(mem_addr), 128'(0));
    check("rst_mem_wdata", mem_wdata, 128'(0));
    check("rst_rdata", 128'(rdata), 128'(0));
    @(posedge clk); #1;

    // Clean miss, then hit.
    do_access(32'h40, 1'b0, '0, 1'b0, 2, "t1_miss");
    check("t1_rd_seen", 128'(rd_seen), 128'(1));
    check("t1_rd_addr", 128'(rd_addr), 128'(32'h40));
    check("t1_no_wb", 128'(wr_seen), 128'(0));
    do_access(32'h40, 1'b0, '0, 1'b0, 0, "t1_hit");
    check("t1_hit_no_mem", 128'(rd_seen), 128'(0));

    // Write hit stays local.
    do_access(32'h44, 1'b1, 32'hDEAD_BEEF, 1'b0, 0, "t2_wr");
    check("t2_no_rd", 128'(rd_seen), 128'(0));
    check("t2_no_wb", 128'(wr_seen), 128'(0));
    do_access(32'h44, 1'b0, '0, 1'b0, 0, "t2_rd");

    // Dirty eviction: write-back of 0x40 before refill of 0x1040.
    n_wb = wb_addr_q.size();
    do_access(32'h1040, 1'b0, '0, 1'b0, 3, "t3_evict");
    check("t3_wb_seen", 128'(wr_seen), 128'(1));
    check("t3_wb_addr", 128'(wr_addr), 128'(32'h40));
    check("t3_rd_addr", 128'(rd_addr), 128'(32'h1040));
    check("t3_wb_count", 128'(wb_addr_q.size()), 128'(n_wb + 1));
    check("t3_wb_word1", 128'(wb_data_q[n_wb][63:32]), 128'(32'hDEAD_BEEF));
    check("t3_wb_word0", 128'(wb_data_q[n_wb][31:0]), 128'(pat(32'h40)));
    do_access(32'h44, 1'b0, '0, 1'b0, 2, "t3_back");

    // Flush with two dirty lines, memory latency 3.
    lat = 3;
    do_access(32'h44, 1'b1, 32'h1234_5678, 1'b0, 0, "t4_wr44");
    do_access(32'h80, 1'b1, 32'hCAFE_0080, 1'b0, 4, "t4_wr80");
    n_wb = wb_addr_q.size();
    do_flush(16 + 2 * 3);
    check("t4_wb_count", 128'(wb_addr_q.size()), 128'(n_wb + 2));
    if (wb_addr_q.size() >= n_wb + 2) begin
      check("t4_wb0_addr", 128'(wb_addr_q[n_wb]), 128'(32'h40));
      check("t4_wb1_addr", 128'(wb_addr_q[n_wb + 1]), 128'(32'h80));
    end
    do_access(32'h44, 1'b0, '0, 1'b0, 4, "t4_miss44");
    check("t4_miss44_rd", 128'(rd_seen), 128'(1));
    do_access(32'h80, 1'b0, '0, 1'b0, 4, "t4_miss80");

    // Reset during refill.
    lat = 5;
    address = 32'hC0;
    read    = 1'b1;
    @(posedge clk); #2;
    check("t5_refill_req", 128'(mem_read), 128'(1));
    check("t5_refill_addr", 128'(mem_addr), 128'(32'hC0));
    rst  = 1'b0;
    read = 1'b0;
    @(posedge clk); #2;
    check("t5_rst_mem_read", 128'(mem_read), 128'(0));
    check("t5_rst_mem_write", 128'(mem_write), 128'(0));
    check("t5_rst_stall", 128'(stall), 128'(0));
    check("t5_rst_mem_addr", 128'(mem_addr), 128'(0));
    rst = 1'b1;
    @(posedge clk); #1;
    lat = 2;
    do_access(32'hC0, 1'b0, '0, 1'b0, 3, "t5_retry");
    check("t5_retry_rd", 128'(rd_seen), 128'(1));
    do_access(32'h80, 1'b0, '0, 1'b0, 3, "t5_cleared");

    // Flush and read together: clean flush first, then the read misses and refills.
    do_access(32'hC0, 1'b0, '0, 1'b1, 1 + 16 + 1 + 2, "t6_flush_rd");
    check("t6_rd_addr", 128'(rd_addr), 128'(32'hC0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
